execute_md: RTL and testbench
=============================

# execute_md

Parametrised execute stage for the light RV32 pipeline, generalised to XLEN and extended with an iterative RV32M multiply/divide unit (MDU). It sits between the ID/EX and EX/MEM pipeline registers and keeps the single-cycle ALU path with operand forwarding. It adds a valid bit, a flush input, forwarded store data, and a fixed-latency multi-cycle MDU path that holds upstream via `o_stall` while emitting bubbles downstream.

## Interface
- `XLEN`, default 32 — datapath width; must be ≥ 8.
- `clk`  in  1 — clock; all state updates on the rising edge.
- `reset`  in  1 — synchronous, active-high reset; priority over all other inputs.
- `i_flush`  in  1 — synchronous kill of the current op and of any MDU op in flight.
- `i_forward_SlctA`, `i_forward_SlctB`  in  2 — operand source per operand: 0 = register data, 1 = `i_forward_WBData`, 2 = `i_forward_EXMData`, 3 = register data.
- `i_forward_WBData`, `i_forward_EXMData`  in  XLEN — forwarded values.
- `i_pipe_Valid`  in  1 — the input bundle holds a real instruction.
- `i_pipe_PC`, `i_pipe_Imm`, `i_pipe_Reg1Data`, `i_pipe_Reg2Data`  in  XLEN — operands.
- `i_pipe_RegDst`, `i_pipe_Reg2`  in  5 — register indices, passed through.
- `i_pipe_Alu1Src`  in  1 — ALU A input: 1 = PC, 0 = forwarded A.
- `i_pipe_Alu2Src`  in  2 — ALU B input: 0 = Imm, 1 = forwarded B, 2 = constant 4, 3 = 0.
- `i_pipe_AluCtr`  in  4 — existing ALU opcode.
- `i_pipe_MdEn`  in  1 — the op is an M-extension op; overrides the ALU result.
- `i_pipe_MdFunct`  in  3 — selects the M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `i_pipe_MemToReg`, `i_pipe_RegWrEn`, `i_pipe_MemWrEn`, `i_pipe_Branch`, `i_pipe_Jump`  in  1 — control signals.
- `o_stall`  out  1 — combinational; upstream holds its bundle and does not advance while high.
- `o_pipe_Valid`  out  1 — registered valid.
- `o_pipe_TargetAddr`, `o_pipe_AluResult`  out  XLEN — registered results.
- `o_pipe_Zero`  out  1 — registered zero flag.
- `o_pipe_Reg2Data`  out  XLEN — registered forwarded B (store data).
- `o_pipe_RegDst`, `o_pipe_Reg2`  out  5 — registered pass-through indices.
- `o_pipe_MemToReg`, `o_pipe_RegWrEn`, `o_pipe_MemWrEn`, `o_pipe_Branch`, `o_pipe_Jump`  out  1 — registered controls.

## Operation
**Forwarding and ALU path**
- BusA and BusB are selected by `i_forward_SlctA` and `i_forward_SlctB`.
- The ALU A and B muxes follow the `Alu1Src` and `Alu2Src` encodings above.
- `o_pipe_TargetAddr` = PC + Imm, modulo 2^XLEN, carry dropped.
- `o_pipe_Reg2Data` = BusB, not raw `Reg2Data`.

**Bubbles**
- An output bundle is a bubble when `o_pipe_Valid`, `RegWrEn`, `MemWrEn`, `Branch` and `Jump` are all 0.
- Data fields of a bubble are don't-care.
- `i_pipe_Valid` = 0 produces a bubble.

**Non-MDU op** (`i_pipe_Valid` and not `i_pipe_MdEn`)
- Completes in one cycle with `o_stall` = 0.
- `o_pipe_Zero` = ALU zero flag.

**MDU op**
- FSM states are IDLE, RUN and DONE.
- IDLE with a valid MDU op:
  - `o_stall` = 1.
  - At the edge: forwarded A and B and the funct are captured, the counter is set to 0, and the FSM moves to RUN.
  - Output bundle at that edge = bubble.
- RUN:
  - `o_stall` = 1.
  - One radix-2 step per edge: shift-add for MUL*, restoring divide on magnitudes for DIV*/REM*.
  - The counter increments each edge; when counter = XLEN−1, the FSM moves to DONE.
  - Output bundle at each RUN edge = bubble.
- DONE:
  - `o_stall` = 0.
  - At the edge, the outputs load the MDU result, the still-held input controls and indices, and `o_pipe_Valid` = 1.
  - `o_pipe_Zero` = (result == 0).
  - The FSM returns to IDLE.
- Captured operands are used throughout, so changes on the forward buses during the stall are ignored.

**MDU results**
- MUL returns the low XLEN bits of the product.
- MULH, MULHSU and MULHU return the high XLEN bits of the 2·XLEN product, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0.
- All special cases use the same fixed latency; there is no early exit.

**Flush**
- `i_flush` = 1 forces `o_stall` = 0 combinationally.
- At the edge: the output bundle becomes a bubble and the FSM goes to IDLE, aborting any MDU op.

**Reset**
- All outputs are 0, the FSM is IDLE and the counter is 0.
- `o_stall` = 0 while `reset` is high.
- Reset mid-op behaves like flush, with all output registers zeroed.

## Timing
- ALU op: result appears at the first edge after presentation.
- MDU op:
  - `o_stall` is high for exactly XLEN+1 consecutive cycles (the IDLE capture cycle plus XLEN RUN cycles).
  - The DONE cycle follows with `o_stall` low.
  - The result appears at the edge ending the DONE cycle, XLEN+2 edges after first presentation.
- Upstream must hold the bundle stable while `o_stall` = 1.
- A new instruction, including a back-to-back MDU op, may be presented in the cycle after DONE.
- Downstream sees exactly one valid bundle per MDU op.

## Test plan
- **ALU path with forwarding.** Inputs: `Reg1Data` = 5, `SlctA` = 2, `EXMData` = 100, `Imm` = 7, `Alu2Src` = 0, ADD. Required: `AluResult` = 107 one edge later and `o_stall` never high. Also `SlctB` = 1 with `WBData` = 0x55 → `o_pipe_Reg2Data` = 0x55.
- **Multiply, XLEN = 32.** Inputs: A = 0xFFFFFFFF, B = 3. Required: MUL → 0xFFFFFFFD, MULH → 0xFFFFFFFF, MULHU → 0x00000002, MULHSU → 0xFFFFFFFF. Also required: `o_stall` high for exactly 33 cycles, one valid output per op, and bubbles during the stall.
- **Divide, including special cases.** DIV −7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF. DIVU 7/0 → 0xFFFFFFFF and REMU 7/0 → 7. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0 with `o_pipe_Zero` = 1. All with identical latency.
- **Operand capture.** Present MUL with `SlctA` = 1, `WBData` = 9, B = 2, then change `WBData` to 0 the next cycle. Required: result = 18.
- **Flush and reset mid-op.** Assert `i_flush` in RUN cycle 10. Required: `o_stall` = 0 in that cycle, the next output is a bubble, and a following ADD completes in 1 cycle. Repeat with `reset`: all outputs are 0 after the edge.
- **XLEN = 16 build.** Inputs: MULHU 0xFFFF × 0xFFFF. Required: 0xFFFE, with `o_stall` high for exactly 17 cycles.

Source files
------------

// File: rtl/execute_md_if.sv
// Purpose: pipeline bundle between ID/EX and EX/MEM for the execute stage.
// Ports (signals):
//   i_*  : forwarding selects/data, flush and the ID/EX input bundle
//   o_*  : stall request and the registered EX/MEM output bundle
// Modports: master (pipeline driver / bench), slave (execute stage).
interface execute_md_if #(
   parameter int unsigned XLEN = 32
);
   logic            i_flush;
   logic [1:0]      i_forward_SlctA;
   logic [1:0]      i_forward_SlctB;
   logic [XLEN-1:0] i_forward_WBData;
   logic [XLEN-1:0] i_forward_EXMData;
   logic            i_pipe_Valid;
   logic [XLEN-1:0] i_pipe_PC;
   logic [XLEN-1:0] i_pipe_Imm;
   logic [XLEN-1:0] i_pipe_Reg1Data;
   logic [XLEN-1:0] i_pipe_Reg2Data;
   logic [4:0]      i_pipe_RegDst;
   logic [4:0]      i_pipe_Reg2;
   logic            i_pipe_Alu1Src;
   logic [1:0]      i_pipe_Alu2Src;
   logic [3:0]      i_pipe_AluCtr;
   logic            i_pipe_MdEn;
   logic [2:0]      i_pipe_MdFunct;
   logic            i_pipe_MemToReg;
   logic            i_pipe_RegWrEn;
   logic            i_pipe_MemWrEn;
   logic            i_pipe_Branch;
   logic            i_pipe_Jump;

   logic            o_stall;
   logic            o_pipe_Valid;
   logic [XLEN-1:0] o_pipe_TargetAddr;
   logic [XLEN-1:0] o_pipe_AluResult;
   logic            o_pipe_Zero;
   logic [XLEN-1:0] o_pipe_Reg2Data;
   logic [4:0]      o_pipe_RegDst;
   logic [4:0]      o_pipe_Reg2;
   logic            o_pipe_MemToReg;
   logic            o_pipe_RegWrEn;
   logic            o_pipe_MemWrEn;
   logic            o_pipe_Branch;
   logic            o_pipe_Jump;

   modport master (
      output i_flush, i_forward_SlctA, i_forward_SlctB, i_forward_WBData,
             i_forward_EXMData, i_pipe_Valid, i_pipe_PC, i_pipe_Imm,
             i_pipe_Reg1Data, i_pipe_Reg2Data, i_pipe_RegDst, i_pipe_Reg2,
             i_pipe_Alu1Src, i_pipe_Alu2Src, i_pipe_AluCtr, i_pipe_MdEn,
             i_pipe_MdFunct, i_pipe_MemToReg, i_pipe_RegWrEn, i_pipe_MemWrEn,
             i_pipe_Branch, i_pipe_Jump,
      input  o_stall, o_pipe_Valid, o_pipe_TargetAddr, o_pipe_AluResult,
             o_pipe_Zero, o_pipe_Reg2Data, o_pipe_RegDst, o_pipe_Reg2,
             o_pipe_MemToReg, o_pipe_RegWrEn, o_pipe_MemWrEn, o_pipe_Branch,
             o_pipe_Jump
   );

   modport slave (
      input  i_flush, i_forward_SlctA, i_forward_SlctB, i_forward_WBData,
             i_forward_EXMData, i_pipe_Valid, i_pipe_PC, i_pipe_Imm,
             i_pipe_Reg1Data, i_pipe_Reg2Data, i_pipe_RegDst, i_pipe_Reg2,
             i_pipe_Alu1Src, i_pipe_Alu2Src, i_pipe_AluCtr, i_pipe_MdEn,
             i_pipe_MdFunct, i_pipe_MemToReg, i_pipe_RegWrEn, i_pipe_MemWrEn,
             i_pipe_Branch, i_pipe_Jump,
      output o_stall, o_pipe_Valid, o_pipe_TargetAddr, o_pipe_AluResult,
             o_pipe_Zero, o_pipe_Reg2Data, o_pipe_RegDst, o_pipe_Reg2,
             o_pipe_MemToReg, o_pipe_RegWrEn, o_pipe_MemWrEn, o_pipe_Branch,
             o_pipe_Jump
   );
endinterface

// File: rtl/execute_md.sv
// Purpose: RV32 execute stage with forwarding, single-cycle ALU and an
//          iterative radix-2 multiply/divide unit (fixed XLEN-step latency).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : execute_md_if.slave -- input bundle, forwarding, flush, stall
//           request and the registered EX/MEM output bundle
module execute_md #(
   parameter int unsigned XLEN = 32
) (
   input logic         clk,
   input logic         reset,
   execute_md_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned PW = 2 * XLEN;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      funct_q, funct_d;
   logic [XLEN-1:0] opb_q, opb_d;     // multiplicand or divisor magnitude
   logic [PW-1:0]   acc_q, acc_d;     // {hi, lo}: product, or {rem, quo}
   logic [XLEN-1:0] dvd_q, dvd_d;     // raw dividend for divide-by-zero
   logic            sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;

   logic            valid_q, valid_d, zero_q, zero_d;
   logic [XLEN-1:0] tgt_q, tgt_d, res_q, res_d, st_q, st_d;
   logic [4:0]      rd_q, rd_d, r2_q, r2_d;
   logic            m2r_q, m2r_d, rwe_q, rwe_d, mwe_q, mwe_d;
   logic            br_q, br_d, jmp_q, jmp_d;
   logic            stall_c;

   logic [XLEN-1:0] bus_a, bus_b, alu_a, alu_b, alu_res;
   logic [XLEN-1:0] mag_a, mag_b, quo, rem, mdu_res;
   logic            sgn_a, sgn_b, neg_a, neg_b;
   logic [XLEN:0]   mul_sum, div_shift, div_trial;
   logic [PW-1:0]   mul_next, div_next, prod;

   // Operand forwarding and ALU input muxes
   always_comb begin
      case (bus.i_forward_SlctA)
         2'd1:    bus_a = bus.i_forward_WBData;
         2'd2:    bus_a = bus.i_forward_EXMData;
         default: bus_a = bus.i_pipe_Reg1Data;
      endcase
      case (bus.i_forward_SlctB)
         2'd1:    bus_b = bus.i_forward_WBData;
         2'd2:    bus_b = bus.i_forward_EXMData;
         default: bus_b = bus.i_pipe_Reg2Data;
      endcase
      alu_a = bus.i_pipe_Alu1Src ? bus.i_pipe_PC : bus_a;
      case (bus.i_pipe_Alu2Src)
         2'd0:    alu_b = bus.i_pipe_Imm;
         2'd1:    alu_b = bus_b;
         2'd2:    alu_b = XLEN'(4);
         default: alu_b = '0;
      endcase
   end

   // Single-cycle ALU
   always_comb begin
      case (bus.i_pipe_AluCtr)
         ALU_ADD:  alu_res = alu_a + alu_b;
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_SLL:  alu_res = alu_a << alu_b[CW-1:0];
         ALU_SRL:  alu_res = alu_a >> alu_b[CW-1:0];
         ALU_SRA:  alu_res = $signed(alu_a) >>> alu_b[CW-1:0];
         ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
         ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
         default:  alu_res = alu_a + alu_b;
      endcase
   end

   // MDU datapath: operand magnitudes, one radix-2 step, sign-corrected result
   always_comb begin
      sgn_a = (bus.i_pipe_MdFunct == 3'd1) || (bus.i_pipe_MdFunct == 3'd2) ||
              (bus.i_pipe_MdFunct == 3'd4) || (bus.i_pipe_MdFunct == 3'd6);
      sgn_b = (bus.i_pipe_MdFunct == 3'd1) || (bus.i_pipe_MdFunct == 3'd4) ||
              (bus.i_pipe_MdFunct == 3'd6);
      neg_a = sgn_a & bus_a[XLEN-1];
      neg_b = sgn_b & bus_b[XLEN-1];
      mag_a = neg_a ? -bus_a : bus_a;
      mag_b = neg_b ? -bus_b : bus_b;

      mul_sum   = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
      div_trial = div_shift - {1'b0, opb_q};
      if (!div_trial[XLEN]) begin
         div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end

      prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo  = acc_q[XLEN-1:0];
      rem  = acc_q[PW-1:XLEN];
      case (funct_q)
         3'd0:       mdu_res = prod[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:       mdu_res = prod[PW-1:XLEN];
         3'd4, 3'd5: mdu_res = bz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
         default:    mdu_res = bz_q ? dvd_q : (sa_q ? -rem : rem);
      endcase
   end

   // Next-state, MDU sequencing and output bundle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      funct_d = funct_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      dvd_d   = dvd_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      bz_d    = bz_q;
      stall_c = 1'b0;
      // Bubble by default; data fields still follow the ALU path
      valid_d = 1'b0;
      m2r_d   = 1'b0;
      rwe_d   = 1'b0;
      mwe_d   = 1'b0;
      br_d    = 1'b0;
      jmp_d   = 1'b0;
      tgt_d   = bus.i_pipe_PC + bus.i_pipe_Imm;
      res_d   = alu_res;
      zero_d  = (alu_res == '0);
      st_d    = bus_b;
      rd_d    = bus.i_pipe_RegDst;
      r2_d    = bus.i_pipe_Reg2;

      if (bus.i_flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_pipe_Valid && bus.i_pipe_MdEn) begin
                  stall_c = 1'b1;
                  funct_d = bus.i_pipe_MdFunct;
                  opb_d   = bus.i_pipe_MdFunct[2] ? mag_b : mag_a;
                  acc_d   = {XLEN'(0), bus.i_pipe_MdFunct[2] ? mag_a : mag_b};
                  dvd_d   = bus_a;
                  sa_d    = neg_a;
                  sb_d    = neg_b;
                  bz_d    = (bus_b == '0);
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else if (bus.i_pipe_Valid) begin
                  valid_d = 1'b1;
                  m2r_d   = bus.i_pipe_MemToReg;
                  rwe_d   = bus.i_pipe_RegWrEn;
                  mwe_d   = bus.i_pipe_MemWrEn;
                  br_d    = bus.i_pipe_Branch;
                  jmp_d   = bus.i_pipe_Jump;
               end
            end
            S_RUN: begin
               stall_c = 1'b1;
               acc_d   = funct_q[2] ? div_next : mul_next;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN - 1)) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               valid_d = 1'b1;
               res_d   = mdu_res;
               zero_d  = (mdu_res == '0);
               m2r_d   = bus.i_pipe_MemToReg;
               rwe_d   = bus.i_pipe_RegWrEn;
               mwe_d   = bus.i_pipe_MemWrEn;
               br_d    = bus.i_pipe_Branch;
               jmp_d   = bus.i_pipe_Jump;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         funct_q <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         dvd_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bz_q    <= 1'b0;
         valid_q <= 1'b0;
         tgt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         st_q    <= '0;
         rd_q    <= '0;
         r2_q    <= '0;
         m2r_q   <= 1'b0;
         rwe_q   <= 1'b0;
         mwe_q   <= 1'b0;
         br_q    <= 1'b0;
         jmp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         funct_q <= funct_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         dvd_q   <= dvd_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bz_q    <= bz_d;
         valid_q <= valid_d;
         tgt_q   <= tgt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         st_q    <= st_d;
         rd_q    <= rd_d;
         r2_q    <= r2_d;
         m2r_q   <= m2r_d;
         rwe_q   <= rwe_d;
         mwe_q   <= mwe_d;
         br_q    <= br_d;
         jmp_q   <= jmp_d;
      end
   end

   assign bus.o_stall           = stall_c & ~reset;
   assign bus.o_pipe_Valid      = valid_q;
   assign bus.o_pipe_TargetAddr = tgt_q;
   assign bus.o_pipe_AluResult  = res_q;
   assign bus.o_pipe_Zero       = zero_q;
   assign bus.o_pipe_Reg2Data   = st_q;
   assign bus.o_pipe_RegDst     = rd_q;
   assign bus.o_pipe_Reg2       = r2_q;
   assign bus.o_pipe_MemToReg   = m2r_q;
   assign bus.o_pipe_RegWrEn    = rwe_q;
   assign bus.o_pipe_MemWrEn    = mwe_q;
   assign bus.o_pipe_Branch     = br_q;
   assign bus.o_pipe_Jump       = jmp_q;
endmodule

// File: tb/tb_execute_md.sv
// Purpose: directed, table-driven bench for execute_md (XLEN 32 and 16 builds).
module tb_execute_md;
   logic clk = 1'b0;
   logic rst32, rst16;
   always #5 clk = ~clk;

   execute_md_if #(.XLEN(32)) b32 ();
   execute_md_if #(.XLEN(16)) b16 ();

   execute_md #(.XLEN(32)) dut32 (.clk(clk), .reset(rst32), .bus(b32.slave));
   execute_md #(.XLEN(16)) dut16 (.clk(clk), .reset(rst16), .bus(b16.slave));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0]  sa, sb;
      logic [31:0] r1, r2, wb, exm, imm, pc;
      logic        a1;
      logic [1:0]  a2;
      logic [3:0]  op;
      logic [31:0] res, tgt, st;
      logic        z;
   } alu_vec_t;

   typedef struct {
      logic [2:0]  f;
      logic [1:0]  sa;
      logic [31:0] a, b, res;
      logic        z;
   } md_vec_t;

   alu_vec_t av[6];
   md_vec_t  mv[18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle32();
      b32.i_flush = 0; b32.i_forward_SlctA = 0; b32.i_forward_SlctB = 0;
      b32.i_forward_WBData = 0; b32.i_forward_EXMData = 0; b32.i_pipe_Valid = 0;
      b32.i_pipe_PC = 0; b32.i_pipe_Imm = 0; b32.i_pipe_Reg1Data = 0; b32.i_pipe_Reg2Data = 0;
      b32.i_pipe_RegDst = 0; b32.i_pipe_Reg2 = 0; b32.i_pipe_Alu1Src = 0; b32.i_pipe_Alu2Src = 0;
      b32.i_pipe_AluCtr = 0; b32.i_pipe_MdEn = 0; b32.i_pipe_MdFunct = 0; b32.i_pipe_MemToReg = 0;
      b32.i_pipe_RegWrEn = 0; b32.i_pipe_MemWrEn = 0; b32.i_pipe_Branch = 0; b32.i_pipe_Jump = 0;
   endtask

   task automatic idle16();
      b16.i_flush = 0; b16.i_forward_SlctA = 0; b16.i_forward_SlctB = 0;
      b16.i_forward_WBData = 0; b16.i_forward_EXMData = 0; b16.i_pipe_Valid = 0;
      b16.i_pipe_PC = 0; b16.i_pipe_Imm = 0; b16.i_pipe_Reg1Data = 0; b16.i_pipe_Reg2Data = 0;
      b16.i_pipe_RegDst = 0; b16.i_pipe_Reg2 = 0; b16.i_pipe_Alu1Src = 0; b16.i_pipe_Alu2Src = 0;
      b16.i_pipe_AluCtr = 0; b16.i_pipe_MdEn = 0; b16.i_pipe_MdFunct = 0; b16.i_pipe_MemToReg = 0;
      b16.i_pipe_RegWrEn = 0; b16.i_pipe_MemWrEn = 0; b16.i_pipe_Branch = 0; b16.i_pipe_Jump = 0;
   endtask

   task automatic chk_bubble32(input string name);
      chk(name, 64'({b32.o_pipe_Valid, b32.o_pipe_RegWrEn, b32.o_pipe_MemWrEn,
                     b32.o_pipe_Branch, b32.o_pipe_Jump}), 64'd0);
   endtask

   task automatic chk_zero32(input string name);
      chk({name, "_ctrl"}, 64'({b32.o_pipe_Valid, b32.o_pipe_Zero, b32.o_pipe_RegDst,
                               b32.o_pipe_Reg2, b32.o_pipe_MemToReg, b32.o_pipe_RegWrEn,
                               b32.o_pipe_MemWrEn, b32.o_pipe_Branch, b32.o_pipe_Jump}), 64'd0);
      chk({name, "_data"}, 64'(b32.o_pipe_AluResult | b32.o_pipe_TargetAddr |
                               b32.o_pipe_Reg2Data), 64'd0);
   endtask

   // Present one ALU vector (called right after an edge) and check it one edge later
   task automatic apply_alu(input alu_vec_t v, input int id);
      b32.i_flush = 0; b32.i_pipe_Valid = 1; b32.i_pipe_MdEn = 0;
      b32.i_forward_SlctA = v.sa; b32.i_forward_SlctB = v.sb;
      b32.i_pipe_Reg1Data = v.r1; b32.i_pipe_Reg2Data = v.r2;
      b32.i_forward_WBData = v.wb; b32.i_forward_EXMData = v.exm;
      b32.i_pipe_Imm = v.imm; b32.i_pipe_PC = v.pc;
      b32.i_pipe_Alu1Src = v.a1; b32.i_pipe_Alu2Src = v.a2; b32.i_pipe_AluCtr = v.op;
      b32.i_pipe_RegDst = 5'(id + 1); b32.i_pipe_Reg2 = 5'(id + 10);
      b32.i_pipe_RegWrEn = 1; b32.i_pipe_MemWrEn = 0; b32.i_pipe_Branch = 0; b32.i_pipe_Jump = 0;
      @(negedge clk);
      chk($sformatf("alu%0d_stall", id), 64'(b32.o_stall), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("alu%0d_res", id),   64'(b32.o_pipe_AluResult), 64'(v.res));
      chk($sformatf("alu%0d_tgt", id),   64'(b32.o_pipe_TargetAddr), 64'(v.tgt));
      chk($sformatf("alu%0d_st", id),    64'(b32.o_pipe_Reg2Data), 64'(v.st));
      chk($sformatf("alu%0d_zero", id),  64'(b32.o_pipe_Zero), 64'(v.z));
      chk($sformatf("alu%0d_ctrl", id),  64'({b32.o_pipe_Valid, b32.o_pipe_RegWrEn, b32.o_pipe_RegDst}),
          64'({1'b1, 1'b1, 5'(id + 1)}));
      idle32();
   endtask

   task automatic drive_md32(input logic [2:0] f, input logic [1:0] sa,
                             input logic [31:0] a, input logic [31:0] b);
      b32.i_flush = 0; b32.i_pipe_Valid = 1; b32.i_pipe_MdEn = 1; b32.i_pipe_MdFunct = f;
      b32.i_forward_SlctA = sa; b32.i_forward_SlctB = 0;
      b32.i_pipe_Reg1Data = (sa == 2'd1) ? 32'hA5A5_0000 : a;
      b32.i_forward_WBData = (sa == 2'd1) ? a : 32'h0;
      b32.i_forward_EXMData = 0; b32.i_pipe_Reg2Data = b;
      b32.i_pipe_Alu1Src = 0; b32.i_pipe_Alu2Src = 1; b32.i_pipe_AluCtr = 0;
      b32.i_pipe_RegDst = 5'd7; b32.i_pipe_RegWrEn = 1;
      b32.i_pipe_MemWrEn = 0; b32.i_pipe_Branch = 0; b32.i_pipe_Jump = 0;
   endtask

   // Run one MDU op to its single valid output, counting stall cycles and edges
   task automatic md32(input md_vec_t v, output logic [31:0] res, output logic z,
                       output int stalls, output int edges, output int bad);
      drive_md32(v.f, v.sa, v.a, v.b);
      stalls = 0; edges = 0; bad = 0;
      while (edges < 100) begin
         @(negedge clk);
         if (b32.o_stall) stalls++;
         @(posedge clk); #1;
         edges++;
         if (edges == 1) begin
            b32.i_forward_WBData  = 32'h0;
            b32.i_forward_EXMData = 32'hFFFF_FFFF;
         end
         if (b32.o_pipe_Valid) break;
         if ({b32.o_pipe_RegWrEn, b32.o_pipe_MemWrEn, b32.o_pipe_Branch, b32.o_pipe_Jump} != 4'd0)
            bad++;
      end
      res = b32.o_pipe_AluResult;
      z   = b32.o_pipe_Zero;
      idle32();
   endtask

   task automatic md16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic z, output int stalls, output int edges);
      b16.i_pipe_Valid = 1; b16.i_pipe_MdEn = 1; b16.i_pipe_MdFunct = f;
      b16.i_pipe_Reg1Data = a; b16.i_pipe_Reg2Data = b; b16.i_pipe_RegWrEn = 1;
      stalls = 0; edges = 0;
      while (edges < 100) begin
         @(negedge clk);
         if (b16.o_stall) stalls++;
         @(posedge clk); #1;
         edges++;
         if (b16.o_pipe_Valid) break;
      end
      res = b16.o_pipe_AluResult;
      z   = b16.o_pipe_Zero;
      idle16();
   endtask

   initial begin
      logic [31:0] r;
      logic [15:0] r16;
      logic        z;
      int          st, ed, bad;

      av[0] = '{2'd2, 2'd0, 32'd5,  32'h11, 32'h0,  32'd100, 32'd7,  32'h100,      1'b0, 2'd0, 4'd0, 32'd107, 32'h107, 32'h11, 1'b0};
      av[1] = '{2'd0, 2'd1, 32'h55, 32'h0,  32'h55, 32'h0,   32'h8,  32'h40,       1'b0, 2'd1, 4'd1, 32'h0,   32'h48,  32'h55, 1'b1};
      av[2] = '{2'd0, 2'd0, 32'h0,  32'h0,  32'h0,  32'h0,   32'h20, 32'h200,      1'b1, 2'd2, 4'd0, 32'h204, 32'h220, 32'h0,  1'b0};
      av[3] = '{2'd3, 2'd3, 32'hF0, 32'hAA, 32'h0,  32'h0,   32'h4,  32'h10,       1'b0, 2'd3, 4'd3, 32'hF0,  32'h14,  32'hAA, 1'b0};
      av[4] = '{2'd1, 2'd0, 32'h0,  32'h33, 32'h0F, 32'h0,   32'h20, 32'hFFFF_FFF0, 1'b0, 2'd0, 4'd2, 32'h0,   32'h10,  32'h33, 1'b1};
      av[5] = '{2'd0, 2'd2, 32'h70, 32'h0,  32'h0,  32'h77,  32'h0,  32'h0,        1'b0, 2'd1, 4'd4, 32'h07,  32'h0,   32'h77, 1'b0};

      mv[0]  = '{3'd0, 2'd0, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 1'b0};
      mv[1]  = '{3'd1, 2'd0, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF, 1'b0};
      mv[2]  = '{3'd3, 2'd0, 32'hFFFF_FFFF, 32'd3,         32'h0000_0002, 1'b0};
      mv[3]  = '{3'd2, 2'd0, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF, 1'b0};
      mv[4]  = '{3'd4, 2'd0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
      mv[5]  = '{3'd6, 2'd0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
      mv[6]  = '{3'd5, 2'd0, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0};
      mv[7]  = '{3'd7, 2'd0, 32'd7,         32'd0,         32'd7,         1'b0};
      mv[8]  = '{3'd4, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
      mv[9]  = '{3'd6, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1};
      mv[10] = '{3'd4, 2'd0, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0};
      mv[11] = '{3'd6, 2'd0, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0};
      mv[12] = '{3'd4, 2'd0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
      mv[13] = '{3'd6, 2'd0, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
      mv[14] = '{3'd5, 2'd0, 32'd100,       32'd7,         32'd14,        1'b0};
      mv[15] = '{3'd1, 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
      mv[16] = '{3'd0, 2'd1, 32'd9,         32'd2,         32'd18,        1'b0};
      mv[17] = '{3'd0, 2'd0, 32'h1234,      32'h10,        32'h12340,     1'b0};

      // Reset state, and stall held low under reset even with an MDU op present
      rst32 = 1; rst16 = 1;
      idle32(); idle16();
      repeat (2) @(posedge clk);
      #1;
      chk_zero32("reset");
      drive_md32(3'd4, 2'd0, 32'd7, 32'd2);
      #1;
      chk("reset_stall", 64'(b32.o_stall), 64'd0);
      idle32();
      rst32 = 0; rst16 = 0;

      // ALU path with forwarding
      for (int i = 0; i < 6; i++) apply_alu(av[i], i);

      // Invalid input gives a bubble
      @(posedge clk); #1;
      chk_bubble32("invalid_bubble");

      // MDU ops, presented back to back
      for (int i = 0; i < 18; i++) begin
         md32(mv[i], r, z, st, ed, bad);
         chk($sformatf("md%0d_res", i),     64'(r),   64'(mv[i].res));
         chk($sformatf("md%0d_zero", i),    64'(z),   64'(mv[i].z));
         chk($sformatf("md%0d_stalls", i),  64'(st),  64'd33);
         chk($sformatf("md%0d_edges", i),   64'(ed),  64'd34);
         chk($sformatf("md%0d_bubbles", i), 64'(bad), 64'd0);
      end

      // Flush in RUN cycle 10
      drive_md32(3'd4, 2'd0, 32'd100, 32'd3);
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("flush_pre_stall", 64'(b32.o_stall), 64'd1);
      b32.i_flush = 1;
      #1;
      chk("flush_stall", 64'(b32.o_stall), 64'd0);
      @(posedge clk); #1;
      chk_bubble32("flush_bubble");
      idle32();
      apply_alu(av[0], 10);
      md32(mv[14], r, z, st, ed, bad);
      chk("post_flush_res", 64'(r), 64'd14);
      chk("post_flush_edges", 64'(ed), 64'd34);

      // Reset in RUN cycle 10
      drive_md32(3'd0, 2'd0, 32'd5, 32'd6);
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst32 = 1;
      #1;
      chk("midrst_stall", 64'(b32.o_stall), 64'd0);
      @(posedge clk); #1;
      chk_zero32("midrst");
      rst32 = 0;
      idle32();
      apply_alu(av[1], 11);
      md32(mv[17], r, z, st, ed, bad);
      chk("post_rst_res", 64'(r), 64'h12340);
      chk("post_rst_edges", 64'(ed), 64'd34);

      // XLEN = 16 build
      md16(3'd3, 16'hFFFF, 16'hFFFF, r16, z, st, ed);
      chk("x16_mulhu_res", 64'(r16), 64'hFFFE);
      chk("x16_mulhu_stalls", 64'(st), 64'd17);
      chk("x16_mulhu_edges", 64'(ed), 64'd18);
      md16(3'd4, 16'h8000, 16'hFFFF, r16, z, st, ed);
      chk("x16_div_ovf", 64'(r16), 64'h8000);
      md16(3'd6, 16'h8000, 16'hFFFF, r16, z, st, ed);
      chk("x16_rem_ovf", 64'(r16), 64'h0);
      chk("x16_rem_zero", 64'(z), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
